instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_fifo and instr_fetch.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 16;

   localparam logic [INSTR_W-1:0] NO_OP = 32'h0;

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; a push is accepted
// while full as long as a pop happens in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   flush_i,
   input  logic   push_i,
   input  entry_t entry_i,
   input  logic   pop_i,
   output entry_t head_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = entry_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives instruction memory and buffers fetched
// words for decode. Define FETCH_BYPASS_EN for zero-latency delivery when empty.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int                 ADDR_W     = 16,
   parameter logic [ADDR_W-1:0]  BOOT_ADDR  = '0,
   parameter int                 MEM_WORDS  = 32,
   parameter int                 FIFO_DEPTH = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                fetch_en_i,
   input  logic                redirect_i,
   input  logic [ADDR_W-1:0]   redirect_pc_i,
   output logic                imem_enable_o,
   output logic [ADDR_W-1:0]   imem_addr_o,
   input  logic [INSTR_W-1:0]  imem_instr_i,
   output logic                instr_valid_o,
   input  logic                instr_ready_i,
   output logic [INSTR_W-1:0]  instr_o,
   output logic [ADDR_W-1:0]   instr_pc_o,
   output logic                halted_o
);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;

   entry_t            fifo_head;
   entry_t            fifo_entry;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;

   logic [ADDR_W-1:0] word_idx;
   logic              in_range;
   logic              fetch_permit;
   logic              fetch_fire;
   logic              bypass_vis;
   logic              bypass_take;

   assign word_idx = pc_q >> 2;
   assign in_range = (32'(word_idx) < 32'(MEM_WORDS));

   // rst_ni gates the combinational outputs so they drop as soon as reset asserts.
   assign fetch_permit = rst_ni && fetch_en_i && !redirect_i && (state_q == FETCH);
   assign fifo_pop     = rst_ni && !redirect_i && !fifo_empty && instr_ready_i;
   assign fetch_fire   = fetch_permit && in_range && (!fifo_full || fifo_pop);

`ifdef FETCH_BYPASS_EN
   assign bypass_vis  = fetch_fire && fifo_empty;
   assign bypass_take = bypass_vis && instr_ready_i;
`else
   assign bypass_vis  = 1'b0;
   assign bypass_take = 1'b0;
`endif

   assign fifo_push        = fetch_fire && !bypass_take;
   assign fifo_entry.pc    = pc_q;
   assign fifo_entry.instr = imem_instr_i;

   assign imem_enable_o = fetch_fire;
   assign imem_addr_o   = rst_ni ? pc_q : '0;
   assign instr_valid_o = (rst_ni && !redirect_i && !fifo_empty) || bypass_vis;
   assign halted_o      = halted_q;

   always_comb begin
      instr_o    = NO_OP;
      instr_pc_o = '0;
      if (bypass_vis) begin
         instr_o    = imem_instr_i;
         instr_pc_o = pc_q;
      end else if (instr_valid_o) begin
         instr_o    = fifo_head.instr;
         instr_pc_o = fifo_head.pc;
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect_i),
      .push_i  (fifo_push),
      .entry_i (fifo_entry),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Redirect overrides everything, including a pending halt.
   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (redirect_i) begin
         pc_d    = {redirect_pc_i[ADDR_W-1:2], 2'b00};
         state_d = FETCH;
      end else if (fetch_permit && !in_range) begin
         state_d = HALT;
      end else if (fetch_fire) begin
         pc_d = pc_q + ADDR_W'(4);
      end
      halted_d = (state_d == HALT);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q     <= BOOT_ADDR;
         state_q  <= FETCH;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic
// compared against a queue-based model of the fetch buffer.
module tb_instr_fetch;

   localparam int MEM_WORDS = 32;
   localparam int DEPTH     = 2;

   typedef struct packed {
      logic [15:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_enable;
   logic [15:0] imem_addr;
   logic [31:0] imem_instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [15:0] instr_pc;
   logic        halted;

   logic [31:0] mem [MEM_WORDS];

   ent_t        q[$];
   logic [15:0] m_pc;
   bit          m_halt;

   int checks = 0;
   int errors = 0;

   instr_fetch #(
      .ADDR_W     (16),
      .BOOT_ADDR  (16'h0000),
      .MEM_WORDS  (MEM_WORDS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .fetch_en_i    (fetch_en),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_enable_o (imem_enable),
      .imem_addr_o   (imem_addr),
      .imem_instr_i  (imem_instr),
      .instr_valid_o (instr_valid),
      .instr_ready_i (instr_ready),
      .instr_o       (instr),
      .instr_pc_o    (instr_pc),
      .halted_o      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational memory; out-of-range reads return a recognisable pattern.
   assign imem_instr = (imem_addr[15:2] < 14'd32) ? mem[imem_addr[6:2]]
                                                  : (32'hBAD0_0000 | {16'h0, imem_addr});

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if ((a >> 2) < 16'(MEM_WORDS)) return mem[a[6:2]];
      return 32'hBAD0_0000 | {16'h0, a};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check_output({tag, "_enable"}, {31'h0, imem_enable}, 32'h0);
      check_output({tag, "_addr"},   {16'h0, imem_addr},   32'h0);
      check_output({tag, "_valid"},  {31'h0, instr_valid}, 32'h0);
      check_output({tag, "_instr"},  instr,                32'h0);
      check_output({tag, "_pc"},     {16'h0, instr_pc},    32'h0);
      check_output({tag, "_halted"}, {31'h0, halted},      32'h0);
   endtask

   task automatic model_reset();
      q.delete();
      m_pc   = 16'h0000;
      m_halt = 1'b0;
   endtask

   // One clock cycle: drive, check against the model, advance the model.
   task automatic apply_stimulus(input bit en, input bit redir, input logic [15:0] rpc, input bit rdy);
      int   sz;
      bit   pop, inr, fire, exp_valid;
      ent_t head, e;
      fetch_en    = en;
      redirect    = redir;
      redirect_pc = rpc;
      instr_ready = rdy;
      #1;
      sz        = q.size();
      pop       = !redir && (sz > 0) && rdy;
      inr       = (m_pc >> 2) < 16'(MEM_WORDS);
      fire      = en && !redir && !m_halt && inr && ((sz < DEPTH) || pop);
      exp_valid = !redir && (sz > 0);
      head      = (sz > 0) ? q[0] : '0;
`ifdef FETCH_BYPASS_EN
      if (fire && sz == 0) begin
         exp_valid  = 1'b1;
         head.pc    = m_pc;
         head.instr = mem_word(m_pc);
      end
`endif
      check_output("enable", {31'h0, imem_enable}, {31'h0, fire});
      check_output("addr",   {16'h0, imem_addr},   {16'h0, m_pc});
      check_output("valid",  {31'h0, instr_valid}, {31'h0, exp_valid});
      if (exp_valid) begin
         check_output("instr",    instr,              head.instr);
         check_output("instr_pc", {16'h0, instr_pc}, {16'h0, head.pc});
      end
      check_output("halted", {31'h0, halted}, {31'h0, m_halt});
      @(posedge clk);
      if (redir) begin
         q.delete();
         m_pc   = rpc & 16'hFFFC;
         m_halt = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (en && !m_halt && !inr) begin
            m_halt = 1'b1;
         end else if (fire) begin
            e.pc    = m_pc;
            e.instr = mem_word(m_pc);
`ifdef FETCH_BYPASS_EN
            if (!(sz == 0 && rdy)) q.push_back(e);
`else
            q.push_back(e);
`endif
            m_pc = m_pc + 16'd4;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
      rst_n       = 1'b0;
      fetch_en    = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0;
      instr_ready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming from boot address with decode always ready.
      repeat (3) apply_stimulus(1, 0, 16'h0, 1);

      // Back-pressure fills the buffer, then drain.
      repeat (5) apply_stimulus(1, 0, 16'h0, 0);
      repeat (3) apply_stimulus(1, 0, 16'h0, 1);
      repeat (3) apply_stimulus(1, 0, 16'h0, 0);

      // Redirect to a misaligned target while full.
      apply_stimulus(1, 1, 16'h0013, 0);
      repeat (3) apply_stimulus(1, 0, 16'h0, 1);

      // Run off the end of memory, then leave HALT via redirect.
      repeat (80) apply_stimulus(1, 0, 16'h0, ($urandom_range(0, 3) != 0));
      repeat (4) apply_stimulus(1, 0, 16'h0, 1);
      apply_stimulus(1, 1, 16'h0000, 1);
      repeat (3) apply_stimulus(1, 0, 16'h0, 1);

      // Top of the address space is out of range.
      apply_stimulus(1, 1, 16'hFFFC, 1);
      repeat (3) apply_stimulus(1, 0, 16'h0, 1);
      apply_stimulus(1, 1, 16'h0040, 1);

      // Random traffic.
      for (int i = 0; i < 150; i++) begin
         apply_stimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                        16'($urandom_range(0, 16'h00A0)), ($urandom_range(0, 3) != 0));
      end

      // Async reset between edges with entries buffered.
      apply_stimulus(1, 1, 16'h0020, 0);
      repeat (4) apply_stimulus(1, 0, 16'h0, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset("async_reset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) apply_stimulus(1, 0, 16'h0, 1);
      repeat (3) apply_stimulus(0, 0, 16'h0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
